lane_sprite_engine: RTL and testbench



---
 rtl/race_pkg.sv | 28 ++
 rtl/btn_edge_sync.sv | 30 +++
 rtl/lane_sprite_engine.sv | 170 +++++++++++++++++
 tb/tb_lane_sprite_engine.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/race_pkg.sv
// Shared types and constants for the racing display: FSM states, lane geometry, sprite size, colours.
// Latency: none (package only).
// Backpressure: none (package only).
package race_pkg;

    // Car motion states: parked in a lane, or sliding toward the target lane
    typedef enum logic {
        IDLE  = 1'b0,
        SLIDE = 1'b1
    } state_t;

    // Lane geometry defaults in pixels
    localparam int DEF_LANE0_X    = 197;
    localparam int DEF_LANE_PITCH = 82;
    localparam int DEF_CAR_Y      = 357;

    // Car sprite dimensions in pixels
    localparam int DEF_SPRITE_W   = 80;
    localparam int DEF_SPRITE_H   = 121;

    // 3-bit colour codes used by the pixel mux
    localparam logic [2:0] COL_BLACK = 3'd0;
    localparam logic [2:0] COL_ROAD  = 3'd1;
    localparam logic [2:0] COL_LINE  = 3'd2;
    localparam logic [2:0] COL_GRASS = 3'd3;
    localparam logic [2:0] COL_CAR   = 3'd4;

endpackage

// File: rtl/btn_edge_sync.sv
// Brings a raw asynchronous button level into clk and emits a one-cycle pulse on its rising edge.
// Latency: pulse is high 2 cycles after the button is first sampled high.
// Backpressure: none; every rising edge yields exactly one pulse.
module btn_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic meta;
    logic sync;
    logic prev;

    // Two-flop synchronizer plus a delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= btn;
            sync <= meta;
            prev <= sync;
        end
    end

    assign pulse = sync & ~prev;

endmodule

// File: rtl/lane_sprite_engine.sv
// Player car engine: buttons -> lane requests, per-frame sliding between lanes, registered sprite hit/ROM address.
// Latency: sprite_hit/rom_addr 1 cycle after hcount/vcount; car_x/lane/moving update the cycle after a frame tick.
// Backpressure: a single request is held; button edges arriving while one is pending or while sliding are dropped.
module lane_sprite_engine
    import race_pkg::*;
#(
    parameter int NUM_LANES  = 3,
    parameter int LANE0_X    = DEF_LANE0_X,
    parameter int LANE_PITCH = DEF_LANE_PITCH,
    parameter int CAR_Y      = DEF_CAR_Y,
    parameter int SPRITE_W   = DEF_SPRITE_W,
    parameter int SPRITE_H   = DEF_SPRITE_H,
    parameter int ADDR_W     = 14,
    parameter int STEP       = 2,
    parameter int RESET_LANE = 1,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    localparam int LANE_W    = $clog2(NUM_LANES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              left,
    input  logic              right,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              sprite_hit,
    output logic [LANE_W-1:0] lane,
    output logic [9:0]        car_x,
    output logic              moving
);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);
    localparam logic [LANE_W-1:0] RST_LANE  = LANE_W'(RESET_LANE);
    localparam logic [LANE_W-1:0] ONE_LANE  = LANE_W'(1);
    localparam logic [9:0]        STEP_PX   = 10'(STEP);

    // Left x of the car when parked in lane idx
    function automatic logic [9:0] lane_x(input logic [LANE_W-1:0] idx);
        return 10'(LANE0_X + int'(idx) * LANE_PITCH);
    endfunction

    // One frame of motion: advance by STEP but never overshoot the target
    function automatic logic [9:0] step_toward(input logic [9:0] cur, input logic [9:0] tgt);
        logic [9:0] nxt;
        nxt = cur;
        if (cur < tgt)
            nxt = ((tgt - cur) > STEP_PX) ? cur + STEP_PX : tgt;
        else if (cur > tgt)
            nxt = ((cur - tgt) > STEP_PX) ? cur - STEP_PX : tgt;
        return nxt;
    endfunction

    logic              left_pulse, right_pulse;
    logic              tick;
    logic              pend, pend_dir, pend_clr, go;
    state_t            state_q, state_d;
    logic [LANE_W-1:0] lane_q, lane_d, target_q, target_d;
    logic [9:0]        car_x_q, car_x_d;
    logic              moving_q, moving_d;
    logic              hit_c;
    logic [ADDR_W-1:0] addr_c;
    logic [10:0]       x_end;

    btn_edge_sync u_left  (.clk(clk), .reset(reset), .btn(left),  .pulse(left_pulse));
    btn_edge_sync u_right (.clk(clk), .reset(reset), .btn(right), .pulse(right_pulse));

    // Motion only happens in blanking, after the last visible pixel, so the sprite never tears
    assign tick = (hcount == 10'(H_ACTIVE)) && (vcount == 10'(V_ACTIVE));

    // Hold one lane request; simultaneous left+right edges cancel out
    always_ff @(posedge clk) begin
        if (reset) begin
            pend     <= 1'b0;
            pend_dir <= 1'b0;
        end else if (pend_clr) begin
            pend     <= 1'b0;
        end else if (!pend && !moving_q && (left_pulse ^ right_pulse)) begin
            pend     <= 1'b1;
            pend_dir <= right_pulse;
        end
    end

    // Motion FSM state and car position registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            lane_q   <= RST_LANE;
            target_q <= RST_LANE;
            car_x_q  <= lane_x(RST_LANE);
            moving_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            target_q <= target_d;
            car_x_q  <= car_x_d;
            moving_q <= moving_d;
        end
    end

    // Next-state: accept a request on a tick (taking the first step at once), then step every tick until parked
    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        target_d = target_q;
        car_x_d  = car_x_q;
        moving_d = moving_q;
        pend_clr = 1'b0;
        go       = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick && pend) begin
                    pend_clr = 1'b1;
                    if (!pend_dir && lane_q != '0) begin
                        target_d = lane_q - ONE_LANE;
                        go       = 1'b1;
                    end else if (pend_dir && lane_q != LAST_LANE) begin
                        target_d = lane_q + ONE_LANE;
                        go       = 1'b1;
                    end
                end
            end
            SLIDE: begin
                if (tick)
                    go = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (go) begin
            car_x_d = step_toward(car_x_q, lane_x(target_d));
            if (car_x_d == lane_x(target_d)) begin
                lane_d   = target_d;
                moving_d = 1'b0;
                state_d  = IDLE;
            end else begin
                moving_d = 1'b1;
                state_d  = SLIDE;
            end
        end
    end

    // Hit window computed at 11 bits so car_x + SPRITE_W cannot wrap at the right edge
    assign x_end = {1'b0, car_x_q} + 11'(SPRITE_W);

    // Combinational hit test and row-exact ROM address for the current raster position
    always_comb begin
        hit_c = ({1'b0, hcount} >= {1'b0, car_x_q}) && ({1'b0, hcount} < x_end) &&
                ({1'b0, vcount} >= 11'(CAR_Y)) && ({1'b0, vcount} < 11'(CAR_Y + SPRITE_H)) &&
                (hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
        addr_c = '0;
        if (hit_c)
            addr_c = ADDR_W'(vcount - 10'(CAR_Y)) * ADDR_W'(SPRITE_W) + ADDR_W'(hcount - car_x_q);
    end

    // Register hit and address so they line up with the combinational ROM output
    always_ff @(posedge clk) begin
        if (reset) begin
            sprite_hit <= 1'b0;
            rom_addr   <= '0;
        end else begin
            sprite_hit <= hit_c;
            rom_addr   <= addr_c;
        end
    end

    assign lane   = lane_q;
    assign car_x  = car_x_q;
    assign moving = moving_q;

endmodule

// File: tb/tb_lane_sprite_engine.sv
// Self-checking bench for lane_sprite_engine with a frame-level reference model of the car.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_lane_sprite_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        left, right;
    logic [9:0]  hcount, vcount;
    logic [13:0] rom_addr;
    logic        sprite_hit;
    logic [1:0]  lane;
    logic [9:0]  car_x;
    logic        moving;

    int total = 0;
    int bad   = 0;

    // Reference model: car position in whole pixels, lane index, one pending request
    int m_lane, m_x, m_tgt;
    bit m_moving, m_pend, m_dir;

    always #5 clk = ~clk;

    lane_sprite_engine dut (
        .clk(clk), .reset(reset), .left(left), .right(right),
        .hcount(hcount), .vcount(vcount), .rom_addr(rom_addr),
        .sprite_hit(sprite_hit), .lane(lane), .car_x(car_x), .moving(moving)
    );

    function automatic int lx(int l);
        return 197 + l * 82;
    endfunction

    // Expected {hit, addr} for a raster position with the car at x
    function automatic logic [14:0] ref_pix(int h, int v, int x);
        bit hit;
        hit = (h >= x) && (h < x + 80) && (v >= 357) && (v < 357 + 121) && (h < 640) && (v < 480);
        return {hit, hit ? 14'((v - 357) * 80 + (h - x)) : 14'd0};
    endfunction

    task automatic m_reset();
        m_lane = 1; m_x = lx(1); m_tgt = 1; m_moving = 0; m_pend = 0; m_dir = 0;
    endtask

    task automatic m_press(bit l, bit r);
        if ((l ^ r) && !m_pend && !m_moving) begin
            m_pend = 1;
            m_dir  = r;
        end
    endtask

    task automatic m_tick();
        int d;
        if (!m_moving && m_pend) begin
            m_pend = 0;
            if (!m_dir && m_lane > 0) begin m_tgt = m_lane - 1; m_moving = 1; end
            else if (m_dir && m_lane < 2) begin m_tgt = m_lane + 1; m_moving = 1; end
        end
        if (m_moving) begin
            d = lx(m_tgt) - m_x;
            if (d > 2) m_x = m_x + 2;
            else if (d < -2) m_x = m_x - 2;
            else m_x = lx(m_tgt);
            if (m_x == lx(m_tgt)) begin m_lane = m_tgt; m_moving = 0; end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic park();
        hcount = 10'd700;
        vcount = 10'd500;
    endtask

    task automatic tick();
        hcount = 10'd640;
        vcount = 10'd480;
        cyc();
        park();
        m_tick();
        cyc();
    endtask

    task automatic press(bit l, bit r);
        left = l; right = r;
        repeat (4) cyc();
        left = 0; right = 0;
        repeat (4) cyc();
        m_press(l, r);
    endtask

    task automatic do_reset();
        reset = 1; left = 0; right = 0; park();
        repeat (2) cyc();
        reset = 0;
        cyc();
        m_reset();
    endtask

    task automatic test_reset();
        reset = 1; left = 0; right = 0;
        hcount = 10'd300; vcount = 10'd400;
        repeat (2) cyc();
        if (lane !== 2'd1) begin $display("FAIL reset lane: got %0d want 1", lane); bad++; end
        total++;
        if (car_x !== 10'd279) begin $display("FAIL reset car_x: got %0d want 279", car_x); bad++; end
        total++;
        if (moving !== 1'b0) begin $display("FAIL reset moving: got %0b want 0", moving); bad++; end
        total++;
        if (sprite_hit !== 1'b0) begin $display("FAIL reset hit: got %0b want 0", sprite_hit); bad++; end
        total++;
        if (rom_addr !== 14'd0) begin $display("FAIL reset addr: got %0d want 0", rom_addr); bad++; end
        total++;
        reset = 0; park(); cyc();
        m_reset();
    endtask

    task automatic test_slide_left();
        do_reset();
        press(1, 0);
        for (int k = 1; k <= 41; k++) begin
            tick();
            if ({lane, car_x, moving} !== {(k < 41) ? 2'd1 : 2'd0, 10'(279 - 2 * k), k < 41}) begin
                $display("FAIL slide_left tick %0d: got lane=%0d x=%0d mv=%0b want lane=%0d x=%0d mv=%0b",
                         k, lane, car_x, moving, (k < 41) ? 1 : 0, 279 - 2 * k, k < 41);
                bad++;
            end
            total++;
        end
    endtask

    task automatic test_edge_lanes();
        do_reset();
        press(1, 0); repeat (41) tick();
        press(1, 0); tick();
        if ({lane, car_x, moving} !== {2'd0, 10'd197, 1'b0}) begin
            $display("FAIL edge_lane0: got lane=%0d x=%0d mv=%0b want lane=0 x=197 mv=0", lane, car_x, moving);
            bad++;
        end
        total++;
        press(0, 1); repeat (41) tick();
        press(0, 1); repeat (41) tick();
        if ({lane, car_x, moving} !== {2'd2, 10'd361, 1'b0}) begin
            $display("FAIL reach_lane2: got lane=%0d x=%0d mv=%0b want lane=2 x=361 mv=0", lane, car_x, moving);
            bad++;
        end
        total++;
        press(0, 1); tick();
        if ({lane, car_x, moving} !== {2'd2, 10'd361, 1'b0}) begin
            $display("FAIL edge_lane2: got lane=%0d x=%0d mv=%0b want lane=2 x=361 mv=0", lane, car_x, moving);
            bad++;
        end
        total++;
        press(1, 0); tick();
        if ({lane, car_x, moving} !== {2'd2, 10'd359, 1'b1}) begin
            $display("FAIL pend_cleared: got lane=%0d x=%0d mv=%0b want lane=2 x=359 mv=1", lane, car_x, moving);
            bad++;
        end
        total++;
    endtask

    task automatic test_cancel_and_drop();
        do_reset();
        press(1, 1);
        repeat (3) tick();
        if ({lane, car_x, moving} !== {2'd1, 10'd279, 1'b0}) begin
            $display("FAIL cancel: got lane=%0d x=%0d mv=%0b want lane=1 x=279 mv=0", lane, car_x, moving);
            bad++;
        end
        total++;
        press(1, 0);
        repeat (3) tick();
        press(0, 1);
        repeat (41) tick();
        if ({lane, car_x, moving} !== {2'd0, 10'd197, 1'b0}) begin
            $display("FAIL drop_during_slide: got lane=%0d x=%0d mv=%0b want lane=0 x=197 mv=0", lane, car_x, moving);
            bad++;
        end
        total++;
    endtask

    task automatic test_coincident();
        do_reset();
        left = 1;
        cyc(); cyc();
        hcount = 10'd640; vcount = 10'd480;
        cyc();
        park();
        m_tick(); m_press(1, 0);
        if ({lane, car_x, moving} !== {2'd1, 10'd279, 1'b0}) begin
            $display("FAIL coincident_same_tick: got lane=%0d x=%0d mv=%0b want lane=1 x=279 mv=0", lane, car_x, moving);
            bad++;
        end
        total++;
        cyc(); cyc(); left = 0; repeat (4) cyc();
        tick();
        if ({lane, car_x, moving} !== {2'd1, 10'd277, 1'b1}) begin
            $display("FAIL coincident_next_tick: got lane=%0d x=%0d mv=%0b want lane=1 x=277 mv=1", lane, car_x, moving);
            bad++;
        end
        total++;
    endtask

    task automatic test_raster();
        int th[7] = '{279, 358, 359, 358, 278, 279, 279};
        int tv[7] = '{357, 358, 358, 477, 357, 356, 478};
        logic [14:0] te[7] = '{{1'b1, 14'd0}, {1'b1, 14'd159}, {1'b0, 14'd0}, {1'b1, 14'd9679},
                               {1'b0, 14'd0}, {1'b0, 14'd0}, {1'b0, 14'd0}};
        int h, v;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            hcount = 10'(th[i]); vcount = 10'(tv[i]);
            cyc();
            if ({sprite_hit, rom_addr} !== te[i]) begin
                $display("FAIL raster h=%0d v=%0d: got hit=%0b addr=%0d want hit=%0b addr=%0d",
                         th[i], tv[i], sprite_hit, rom_addr, te[i][14], te[i][13:0]);
                bad++;
            end
            total++;
        end
        for (int i = 0; i < 40; i++) begin
            h = int'($urandom_range(260, 380));
            v = int'($urandom_range(340, 500));
            hcount = 10'(h); vcount = 10'(v);
            cyc();
            if ({sprite_hit, rom_addr} !== ref_pix(h, v, 279)) begin
                $display("FAIL raster_rand h=%0d v=%0d: got hit=%0b addr=%0d want %0h",
                         h, v, sprite_hit, rom_addr, ref_pix(h, v, 279));
                bad++;
            end
            total++;
        end
        park(); cyc();
    endtask

    task automatic test_reset_mid_slide();
        do_reset();
        press(1, 0);
        repeat (9) tick();
        if (car_x !== 10'd261) begin $display("FAIL pre_reset x: got %0d want 261", car_x); bad++; end
        total++;
        hcount = 10'd640; vcount = 10'd480; reset = 1;
        cyc();
        reset = 0; park();
        m_reset();
        if ({lane, car_x, moving} !== {2'd1, 10'd279, 1'b0}) begin
            $display("FAIL reset_mid_slide: got lane=%0d x=%0d mv=%0b want lane=1 x=279 mv=0", lane, car_x, moving);
            bad++;
        end
        total++;
        cyc();
        tick();
        if ({lane, car_x, moving} !== {2'd1, 10'd279, 1'b0}) begin
            $display("FAIL after_reset_tick: got lane=%0d x=%0d mv=%0b want lane=1 x=279 mv=0", lane, car_x, moving);
            bad++;
        end
        total++;
    endtask

    task automatic test_random();
        int op, n, h, v;
        do_reset();
        for (int it = 0; it < 30; it++) begin
            op = int'($urandom_range(0, 3));
            if (op == 0) press(1, 0);
            else if (op == 1) press(0, 1);
            else if (op == 2) press(1, 1);
            n = int'($urandom_range(1, 30));
            for (int k = 0; k < n; k++) begin
                tick();
                if ({lane, car_x, moving} !== {2'(m_lane), 10'(m_x), m_moving}) begin
                    $display("FAIL random it=%0d: got lane=%0d x=%0d mv=%0b want lane=%0d x=%0d mv=%0b",
                             it, lane, car_x, moving, m_lane, m_x, m_moving);
                    bad++;
                end
                total++;
            end
            h = int'($urandom_range(m_x - 10, m_x + 100));
            v = int'($urandom_range(340, 490));
            if (h == 640 && v == 480) h = 0;
            hcount = 10'(h); vcount = 10'(v);
            cyc();
            if ({sprite_hit, rom_addr} !== ref_pix(h, v, m_x)) begin
                $display("FAIL random_pix h=%0d v=%0d x=%0d: got hit=%0b addr=%0d want %0h",
                         h, v, m_x, sprite_hit, rom_addr, ref_pix(h, v, m_x));
                bad++;
            end
            total++;
            park(); cyc();
        end
    endtask

    initial begin
        reset = 1; left = 0; right = 0; park();
        test_reset();
        test_slide_left();
        test_edge_lanes();
        test_cancel_and_drop();
        test_coincident();
        test_raster();
        test_reset_mid_slide();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
